// File: rtl/theremin_input_conditioner_if.sv
// Signal bundle between the theremin front-end conditioner and its neighbours:
// raw antenna/pushbutton inputs in, cleaned square and control buses out.
interface theremin_input_conditioner_if;
    logic       square_in;
    logic [3:0] key_n;
    logic       coe_square_freq;
    logic [1:0] coe_freq_up_down;
    logic [1:0] coe_cal_glis;

    modport master (
        output square_in,
        output key_n,
        input  coe_square_freq,
        input  coe_freq_up_down,
        input  coe_cal_glis
    );

    modport slave (
        input  square_in,
        input  key_n,
        output coe_square_freq,
        output coe_freq_up_down,
        output coe_cal_glis
    );
endinterface

// File: rtl/theremin_input_conditioner.sv
// Synchronizes and cleans the antenna square wave and panel keys, producing
// registered step, calibrate and glissando controls for pitch generation.
module theremin_input_conditioner #(
    parameter int GLITCH_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic                          csi_clk,
    input  logic                          rsi_reset,
    theremin_input_conditioner_if.slave   bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [7:0]    G_LAST = 8'(GLITCH_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_ZERO = DW'(0);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [RW-1:0] R_ZERO = RW'(0);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} step_state_t;

    logic          sq_meta_r, sq_sync_r;
    logic [3:0]    key_meta_r, key_sync_r;
    logic [3:0]    key_press_s;
    logic [7:0]    gcnt_r;
    logic          square_r;
    logic [DW-1:0] dcnt_r [4];
    logic [3:0]    kst_r;
    logic [3:0]    kpe_r;
    step_state_t   step_r [2];
    logic [RW-1:0] rcnt_r [2];
    logic [1:0]    pulse_r;
    logic          cal_r;
    logic          glis_r;

    assign key_press_s = ~key_sync_r;

    // Two-flop synchronizers; keys come out of reset reading "released"
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            sq_meta_r  <= 1'b0;
            sq_sync_r  <= 1'b0;
            key_meta_r <= 4'b1111;
            key_sync_r <= 4'b1111;
        end else begin
            sq_meta_r  <= bus.square_in;
            sq_sync_r  <= sq_meta_r;
            key_meta_r <= bus.key_n;
            key_sync_r <= key_meta_r;
        end
    end

    // Square glitch filter: output follows only after a full stable run
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            gcnt_r   <= 8'd0;
            square_r <= 1'b0;
        end else if (sq_sync_r != square_r) begin
            if (gcnt_r == G_LAST) begin
                square_r <= ~square_r;
                gcnt_r   <= 8'd0;
            end else begin
                gcnt_r <= gcnt_r + 8'd1;
            end
        end else begin
            gcnt_r <= 8'd0;
        end
    end

    // Key debouncers with a one-cycle press strobe on each debounced press
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            for (int i = 0; i < 4; i++) begin
                dcnt_r[i] <= D_ZERO;
            end
            kst_r <= 4'b0000;
            kpe_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                kpe_r[i] <= 1'b0;
                if (key_press_s[i] != kst_r[i]) begin
                    if (dcnt_r[i] == D_LAST) begin
                        kst_r[i]  <= ~kst_r[i];
                        kpe_r[i]  <= ~kst_r[i];
                        dcnt_r[i] <= D_ZERO;
                    end else begin
                        dcnt_r[i] <= dcnt_r[i] + D_ONE;
                    end
                end else begin
                    dcnt_r[i] <= D_ZERO;
                end
            end
        end
    end

    // Step FSMs, index 0 = up, 1 = down; the opposite key vetoes and cancels
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            for (int d = 0; d < 2; d++) begin
                step_r[d] <= IDLE;
                rcnt_r[d] <= R_ZERO;
            end
            pulse_r <= 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                pulse_r[d] <= 1'b0;
                case (step_r[d])
                    IDLE: begin
                        if (kpe_r[d] && !kst_r[1 - d]) begin
                            step_r[d]  <= HOLD;
                            pulse_r[d] <= 1'b1;
                            rcnt_r[d]  <= R_ZERO;
                        end else begin
                            step_r[d] <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (!kst_r[d] || kst_r[1 - d]) begin
                            step_r[d] <= IDLE;
                        end else if (rcnt_r[d] == R_LAST) begin
                            pulse_r[d] <= 1'b1;
                            rcnt_r[d]  <= R_ZERO;
                        end else begin
                            rcnt_r[d] <= rcnt_r[d] + R_ONE;
                        end
                    end
                    default: begin
                        step_r[d] <= IDLE;
                        rcnt_r[d] <= R_ZERO;
                    end
                endcase
            end
        end
    end

    // Calibrate pulse and glissando toggle
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            cal_r  <= 1'b0;
            glis_r <= 1'b0;
        end else begin
            cal_r <= kpe_r[2];
            if (kpe_r[3]) begin
                glis_r <= ~glis_r;
            end else begin
                glis_r <= glis_r;
            end
        end
    end

    assign bus.coe_square_freq  = square_r;
    assign bus.coe_freq_up_down = {pulse_r[0], pulse_r[1]};
    assign bus.coe_cal_glis     = {glis_r, cal_r};
endmodule

// File: tb/tb_theremin_input_conditioner.sv
// Randomized scoreboard bench: a window/arithmetic reference model predicts
// output events per clock edge and a monitor matches what the DUT shows.
module tb_theremin_input_conditioner;
    localparam int G = 3;
    localparam int D = 8;
    localparam int R = 20;
    localparam int HMAX = 16384;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic       csi_clk = 1'b0;
    logic       rsi_reset = 1'b1;
    logic       sq_drv = 1'b0;
    logic [3:0] key_drv = 4'b1111;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;

    theremin_input_conditioner_if bus();
    assign bus.square_in = sq_drv;
    assign bus.key_n     = key_drv;

    theremin_input_conditioner #(
        .GLITCH_CYCLES(G), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
    ) dut (
        .csi_clk(csi_clk), .rsi_reset(rsi_reset), .bus(bus)
    );

    always #5 csi_clk = ~csi_clk;

    // Reference model state: raw history per edge plus output levels
    bit       raw_sq [HMAX];
    bit [3:0] raw_pr [HMAX];
    int       rstart = HMAX;

    // Value the filtering logic sees at edge k: raw input two edges earlier
    function automatic bit smp_sq(int k);
        if (k - 2 < rstart) return 1'b0;
        return raw_sq[k - 2];
    endfunction

    function automatic bit smp_pr(int k, int i);
        if (k - 2 < rstart) return 1'b0;
        return raw_pr[k - 2][i];
    endfunction

    function automatic void push(int t, int kind, int val);
        ev_t e;
        e.cyc = t; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endfunction

    initial begin : model
        bit       m_sq, m_glis, sq_flip, flip, cal_p, glis_p;
        bit [3:0] m_kst, m_kpe, new_kpe;
        bit [1:0] pul;
        int       start_t [2];
        int       t;
        m_sq = 1'b0; m_glis = 1'b0; m_kst = 4'b0; m_kpe = 4'b0;
        start_t[0] = -1; start_t[1] = -1;
        forever begin
            @(posedge csi_clk);
            cyc = cyc + 1;
            t = cyc;
            raw_sq[t] = sq_drv;
            raw_pr[t] = ~key_drv;
            if (rsi_reset) begin
                rstart = t + 1;
                m_sq = 1'b0; m_glis = 1'b0; m_kst = 4'b0; m_kpe = 4'b0;
                start_t[0] = -1; start_t[1] = -1;
            end else begin
                pul = 2'b00;
                cal_p = m_kpe[2];
                glis_p = m_kpe[3];
                for (int d = 0; d < 2; d++) begin
                    if (start_t[d] < 0) begin
                        if (m_kpe[d] && !m_kst[1 - d]) begin
                            start_t[d] = t;
                            pul[d] = 1'b1;
                        end
                    end else if (!m_kst[d] || m_kst[1 - d]) begin
                        start_t[d] = -1;
                    end else if (((t - start_t[d]) % R) == 0) begin
                        pul[d] = 1'b1;
                    end
                end
                sq_flip = 1'b1;
                for (int k = t - G + 1; k <= t; k++)
                    if (smp_sq(k) == m_sq) sq_flip = 1'b0;
                new_kpe = 4'b0;
                for (int i = 0; i < 4; i++) begin
                    flip = 1'b1;
                    for (int k = t - D + 1; k <= t; k++)
                        if (smp_pr(k, i) == m_kst[i]) flip = 1'b0;
                    if (flip) begin
                        m_kst[i] = ~m_kst[i];
                        new_kpe[i] = m_kst[i];
                    end
                end
                m_kpe = new_kpe;
                if (sq_flip) begin
                    m_sq = ~m_sq;
                    push(t, 0, int'(m_sq));
                end
                if (pul[0]) push(t, 1, 1);
                if (pul[1]) push(t, 2, 1);
                if (cal_p) push(t, 3, 1);
                if (glis_p) begin
                    m_glis = ~m_glis;
                    push(t, 4, int'(m_glis));
                end
            end
        end
    end

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: cycle %0d kind=%0d val=%0d, required no event", cyc, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.val != val) begin
                n_fail++;
                $display("FAIL event_match: actual cycle %0d kind=%0d val=%0d, required cycle %0d kind=%0d val=%0d",
                         cyc, kind, val, e.cyc, e.kind, e.val);
            end
        end
    endtask

    initial begin : monitor
        bit  p_sq, p_glis;
        ev_t e;
        p_sq = 1'b0; p_glis = 1'b0;
        forever begin
            @(negedge csi_clk);
            if (rsi_reset) begin
                n_checks++;
                if ({bus.coe_square_freq, bus.coe_freq_up_down, bus.coe_cal_glis} !== 5'b00000) begin
                    n_fail++;
                    $display("FAIL reset_state: outputs=%b required=00000",
                             {bus.coe_square_freq, bus.coe_freq_up_down, bus.coe_cal_glis});
                end
                exp_q.delete();
                p_sq = 1'b0; p_glis = 1'b0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_event: kind=%0d val=%0d required at cycle %0d, absent at cycle %0d",
                             e.kind, e.val, e.cyc, cyc);
                end
                if (bus.coe_square_freq !== p_sq) begin
                    check_ev(0, int'(bus.coe_square_freq));
                    p_sq = bus.coe_square_freq;
                end
                if (bus.coe_freq_up_down[1] !== 1'b0) check_ev(1, 1);
                if (bus.coe_freq_up_down[0] !== 1'b0) check_ev(2, 1);
                if (bus.coe_cal_glis[0] !== 1'b0) check_ev(3, 1);
                if (bus.coe_cal_glis[1] !== p_glis) begin
                    check_ev(4, int'(bus.coe_cal_glis[1]));
                    p_glis = bus.coe_cal_glis[1];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge csi_clk);
            #2;
        end
    endtask

    initial begin : stimulus
        int sq_left;
        int k_left [4];
        ev_t e;
        rsi_reset = 1'b1;
        tick(3);
        rsi_reset = 1'b0;
        // Reset mid-run with square high and glissando key held
        sq_drv = 1'b1; key_drv = 4'b0111;
        tick(30);
        rsi_reset = 1'b1; tick(3); rsi_reset = 1'b0;
        tick(40);
        key_drv = 4'b1111; tick(20);
        // Square glitches of 1, 2 and 3 cycles
        sq_drv = 1'b0; tick(12);
        sq_drv = 1'b1; tick(1); sq_drv = 1'b0; tick(10);
        sq_drv = 1'b1; tick(2); sq_drv = 1'b0; tick(10);
        sq_drv = 1'b1; tick(3); sq_drv = 1'b0; tick(12);
        // Bouncy up press held long enough for auto-repeat
        key_drv = 4'b1110; tick(1); key_drv = 4'b1111; tick(1);
        key_drv = 4'b1110; tick(50);
        key_drv = 4'b1111; tick(30);
        // Down held, up pressed over it, then down released
        key_drv = 4'b1101; tick(50);
        key_drv = 4'b1100; tick(30);
        key_drv = 4'b1110; tick(40);
        key_drv = 4'b1111; tick(20);
        // Glissando three times, then calibrate
        rsi_reset = 1'b1; tick(2); rsi_reset = 1'b0; tick(2);
        for (int n = 0; n < 3; n++) begin
            key_drv = 4'b0111; tick(40);
            key_drv = 4'b1111; tick(20);
        end
        key_drv = 4'b1011; tick(20);
        key_drv = 4'b1111; tick(20);
        // Up and down on the same cycle
        key_drv = 4'b1100; tick(60);
        key_drv = 4'b1111; tick(30);
        // Random bouncy activity with occasional resets
        sq_left = 1;
        for (int i = 0; i < 4; i++) k_left[i] = 1;
        for (int c = 0; c < 2500; c++) begin
            sq_left--;
            if (sq_left <= 0) begin
                sq_drv = ~sq_drv;
                sq_left = int'($urandom_range(1, 6));
            end
            for (int i = 0; i < 4; i++) begin
                k_left[i]--;
                if (k_left[i] <= 0) begin
                    key_drv[i] = ~key_drv[i];
                    k_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                            : int'($urandom_range(5, 70));
                end
            end
            rsi_reset = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        rsi_reset = 1'b0; sq_drv = 1'b0; key_drv = 4'b1111;
        tick(60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL pending_event: kind=%0d val=%0d required at cycle %0d, never seen",
                     e.kind, e.val, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
